// File: rtl/uart_led_cmd_master.sv
// Parses "L<arg><CR|LF>" commands from a UART byte stream into single-cycle Avalon writes on the LED PIO.
// Define UART_LED_CMD_READBACK_EN to accept "L?" which reads the PIO and answers '0' or '1'.
module uart_led_cmd_master #(
    parameter int          TIMEOUT_CYCLES = 5000000,
    parameter logic [7:0]  ACK_CHAR       = 8'h4B,
    parameter logic [7:0]  NAK_CHAR       = 8'h3F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        led_shadow,
    output logic        rx_overrun,
    output logic [2:0]  dbg_state
);

    localparam int             CW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_T  = 8'h54;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    // Handshake: tx_data transfers on a cycle where tx_valid && tx_ready; tx_valid
    // and tx_data stay constant until then. rx_valid is a strobe with no back-pressure.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GOT_L   = 3'd1,
        S_GOT_ARG = 3'd2,
        S_WRITE   = 3'd3,
        S_RESP    = 3'd4
`ifdef UART_LED_CMD_READBACK_EN
        , S_READ  = 3'd5
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          next_bit_q, next_bit_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          cs_q, cs_d;
    logic          wr_n_q, wr_n_d;
    logic          wd_q, wd_d;
    logic          led_q, led_d;
    logic          ovr_q, ovr_d;
`ifdef UART_LED_CMD_READBACK_EN
    logic          is_read_q, is_read_d;
    logic          unused_readdata;
    assign unused_readdata = ^avm_readdata[31:1];
`else
    logic          unused_readdata;
    assign unused_readdata = ^avm_readdata;
`endif

    logic is_term;
    assign is_term = (rx_data == CH_CR) || (rx_data == CH_LF);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        next_bit_d = next_bit_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        cs_d       = cs_q;
        wr_n_d     = wr_n_q;
        wd_d       = wd_q;
        led_d      = led_q;
        ovr_d      = ovr_q;
`ifdef UART_LED_CMD_READBACK_EN
        is_read_d  = is_read_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_valid) begin
                    if (rx_data == CH_L) begin
                        state_d = S_GOT_L;
                    end else if (!is_term) begin
                        state_d    = S_RESP;
                        tx_valid_d = 1'b1;
                        tx_data_d  = NAK_CHAR;
                    end
                end
            end
            S_GOT_L: begin
                if (rx_valid) begin
                    cnt_d   = '0;
                    state_d = S_GOT_ARG;
`ifdef UART_LED_CMD_READBACK_EN
                    is_read_d = 1'b0;
`endif
                    if (rx_data == CH_0) begin
                        next_bit_d = 1'b0;
                    end else if (rx_data == CH_1) begin
                        next_bit_d = 1'b1;
                    end else if (rx_data == CH_T) begin
                        next_bit_d = ~led_q;
`ifdef UART_LED_CMD_READBACK_EN
                    end else if (rx_data == 8'h3F) begin
                        is_read_d = 1'b1;
`endif
                    end else begin
                        state_d    = S_RESP;
                        tx_valid_d = 1'b1;
                        tx_data_d  = NAK_CHAR;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GOT_ARG: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if (is_term) begin
                        cs_d = 1'b1;
`ifdef UART_LED_CMD_READBACK_EN
                        if (is_read_q) begin
                            state_d = S_READ;
                        end else begin
                            state_d = S_WRITE;
                            wr_n_d  = 1'b0;
                            wd_d    = next_bit_q;
                            led_d   = next_bit_q;
                        end
`else
                        state_d = S_WRITE;
                        wr_n_d  = 1'b0;
                        wd_d    = next_bit_q;
                        led_d   = next_bit_q;
`endif
                    end else begin
                        state_d    = S_RESP;
                        tx_valid_d = 1'b1;
                        tx_data_d  = NAK_CHAR;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WRITE: begin
                if (rx_valid) ovr_d = 1'b1;
                cs_d       = 1'b0;
                wr_n_d     = 1'b1;
                state_d    = S_RESP;
                tx_valid_d = 1'b1;
                tx_data_d  = ACK_CHAR;
            end
`ifdef UART_LED_CMD_READBACK_EN
            S_READ: begin
                if (rx_valid) ovr_d = 1'b1;
                // PIO has no wait states, so readdata is valid at the end of this cycle
                cs_d       = 1'b0;
                state_d    = S_RESP;
                tx_valid_d = 1'b1;
                tx_data_d  = avm_readdata[0] ? CH_1 : CH_0;
            end
`endif
            S_RESP: begin
                if (rx_valid) ovr_d = 1'b1;
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            next_bit_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            cs_q       <= 1'b0;
            wr_n_q     <= 1'b1;
            wd_q       <= 1'b0;
            led_q      <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_LED_CMD_READBACK_EN
            is_read_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            next_bit_q <= next_bit_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            cs_q       <= cs_d;
            wr_n_q     <= wr_n_d;
            wd_q       <= wd_d;
            led_q      <= led_d;
            ovr_q      <= ovr_d;
`ifdef UART_LED_CMD_READBACK_EN
            is_read_q  <= is_read_d;
`endif
        end
    end

    assign tx_valid       = tx_valid_q;
    assign tx_data        = tx_data_q;
    assign avm_address    = 2'b00;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wr_n_q;
    assign avm_writedata  = {31'b0, wd_q};
    assign led_shadow     = led_q;
    assign rx_overrun     = ovr_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_uart_led_cmd_master.sv
// Randomized bench for uart_led_cmd_master against a command-level reference model.
module tb_uart_led_cmd_master;

    localparam int         T     = 16;
    localparam logic [7:0] ACK   = 8'h4B;
    localparam logic [7:0] NAK   = 8'h3F;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_T  = 8'h54;
    localparam logic [7:0] CH_Q  = 8'h3F;
    localparam logic [7:0] CH_X  = 8'h78;
`ifdef UART_LED_CMD_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b0;
    logic [31:0] avm_readdata = 32'h0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic        led_shadow;
    logic        rx_overrun;
    logic [2:0]  dbg_state;

    uart_led_cmd_master #(.TIMEOUT_CYCLES(T), .ACK_CHAR(ACK), .NAK_CHAR(NAK)) dut (
        .clk(clk), .reset(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .led_shadow(led_shadow),
        .rx_overrun(rx_overrun), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: a command is the list of bytes accepted so far
    logic        model_led = 1'b0;
    logic        model_ovr = 1'b0;
    logic        pio_bit = 1'b0;
    logic [7:0]  cmd_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] exp_wr_q[$];
    int          exp_rd = 0;
    int          exp_wr_cyc = 0;
    int          exp_rd_cyc = 0;
    int          exp_rise_cyc = 0;
    int          last_cyc = 0;

    function automatic bit model_byte(input logic [7:0] b, input int s);
        bit resp = 1'b0;
        logic [7:0] arg;
        logic nl;
        if (cmd_q.size() > 0 && (s - last_cyc) > T) cmd_q.delete();
        last_cyc = s;
        if (cmd_q.size() == 0) begin
            if (b == CH_L) cmd_q.push_back(b);
            else if (b != CR && b != LF) begin
                exp_q.push_back(NAK); exp_rise_cyc = s; resp = 1'b1;
            end
        end else if (cmd_q.size() == 1) begin
            if (b == CH_0 || b == CH_1 || b == CH_T || (RB && b == CH_Q)) cmd_q.push_back(b);
            else begin
                cmd_q.delete(); exp_q.push_back(NAK); exp_rise_cyc = s; resp = 1'b1;
            end
        end else begin
            arg = cmd_q[1];
            cmd_q.delete();
            resp = 1'b1;
            if (b == CR || b == LF) begin
                exp_rise_cyc = s + 1;
                if (arg == CH_Q) begin
                    exp_rd++; exp_rd_cyc = s;
                    exp_q.push_back(pio_bit ? CH_1 : CH_0);
                end else begin
                    nl = (arg == CH_0) ? 1'b0 : (arg == CH_1) ? 1'b1 : ~model_led;
                    model_led = nl;
                    exp_wr_q.push_back({31'b0, nl}); exp_wr_cyc = s;
                    exp_q.push_back(ACK);
                end
            end else begin
                exp_q.push_back(NAK); exp_rise_cyc = s;
            end
        end
        return resp;
    endfunction

    // scoreboard / bus monitor, sampled on the falling edge
    logic prev_tx = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_tx <= 1'b0;
        end else begin
            if (avm_chipselect) check_eq("addr", {30'b0, avm_address}, 32'h0);
            if (avm_chipselect && !avm_write_n) begin
                check_eq("wr_pending", exp_wr_q.size() > 0, 1);
                if (exp_wr_q.size() > 0) begin
                    check_eq("wr_lat", cyc, exp_wr_cyc);
                    check_eq("wr_data", avm_writedata, exp_wr_q.pop_front());
                end
            end
            if (!avm_write_n) check_eq("wr_n_cs", avm_chipselect, 1);
            if (avm_chipselect && avm_write_n) begin
                check_eq("rd_pending", exp_rd > 0, 1);
                if (exp_rd > 0) begin
                    exp_rd--;
                    check_eq("rd_lat", cyc, exp_rd_cyc);
                end
            end
            if (tx_valid && !prev_tx) check_eq("tx_lat", cyc, exp_rise_cyc);
            if (tx_valid && tx_ready) begin
                check_eq("tx_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check_eq("tx_data", tx_data, exp_q.pop_front());
            end
            prev_tx <= tx_valid;
        end
    end

    // driver tasks; inputs change 2 time units after the rising edge
    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b, output bit resp);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #2;
        rx_valid = 1'b0;
        resp = model_byte(b, cyc);
    endtask

    task automatic wait_resp(input int stall, input bit inject);
        bit got = 1'b0;
        idle(2);
        for (int i = 0; i < stall; i++) begin
            check_eq("tx_hold_valid", tx_valid, 1);
            if (exp_q.size() > 0) check_eq("tx_hold_data", tx_data, exp_q[0]);
            if (inject && i == 0) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom_range(0, 255));
                model_ovr = 1'b1;
            end
            @(posedge clk);
            #2;
            rx_valid = 1'b0;
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (tx_valid) got = 1'b1;
            @(posedge clk);
            #2;
        end
        tx_ready = 1'b0;
        check_eq("resp_seen", got, 1);
    endtask

    function automatic int rand_gap();
        return ($urandom_range(0, 9) < 8) ? $urandom_range(1, 4) : $urandom_range(12, 20);
    endfunction

    // gap: rising edges between consecutive bytes (0 = random per byte)
    task automatic send_seq(input logic [7:0] seq[$], input int gap, input int stall, input bit inject);
        bit r;
        int g;
        foreach (seq[i]) begin
            g = (gap == 0) ? rand_gap() : gap;
            if (i > 0) idle(g - 1);
            send(seq[i], r);
            if (r) wait_resp(stall, inject);
        end
        check_eq("led_shadow", led_shadow, model_led);
        check_eq("rx_overrun", rx_overrun, model_ovr);
    endtask

    task automatic reset_now();
        rst = 1'b1;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        #1;
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_cs", avm_chipselect, 0);
        check_eq("rst_write_n", avm_write_n, 1);
        check_eq("rst_led", led_shadow, 0);
        check_eq("rst_ovr", rx_overrun, 0);
        model_led = 1'b0;
        model_ovr = 1'b0;
        cmd_q.delete();
        exp_q.delete();
        exp_wr_q.delete();
        exp_rd = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic set_pio(input logic b);
        logic [31:0] rnd;
        rnd = $urandom();
        pio_bit = b;
        avm_readdata = {rnd[31:1], b};
    endtask

    logic [7:0] soup_set[8];

    initial begin
        bit r;
        logic [7:0] q[$];
        int n;
        logic [31:0] rv;

        soup_set = '{CH_L, CH_0, CH_1, CH_T, CH_Q, CR, LF, CH_X};

        repeat (3) @(posedge clk);
        #2;
        check_eq("reset_tx_valid", tx_valid, 0);
        check_eq("reset_tx_data", tx_data, 0);
        check_eq("reset_cs", avm_chipselect, 0);
        check_eq("reset_write_n", avm_write_n, 1);
        check_eq("reset_addr", {30'b0, avm_address}, 0);
        check_eq("reset_wdata", avm_writedata, 0);
        check_eq("reset_led", led_shadow, 0);
        check_eq("reset_ovr", rx_overrun, 0);
        check_eq("reset_state", {29'b0, dbg_state}, 0);
        rst = 1'b0;
        idle(1);

        send_seq('{CH_L, CH_1, LF}, 10, 0, 1'b0);
        send_seq('{CH_L, CH_T, CR}, 1, 1, 1'b0);
        send_seq('{CH_L, CH_X}, 1, 0, 1'b0);
        send_seq('{CH_L, CH_0, LF}, 2, 0, 1'b0);
        send_seq('{CH_L, CH_1}, 21, 0, 1'b0);
        send_seq('{LF}, 1, 0, 1'b0);
        send_seq('{CH_L, CH_1, LF}, T, 0, 1'b0);
        send_seq('{CH_L, CH_0, LF}, T + 1, 0, 1'b0);
        send_seq('{CH_L, CH_0, CR, LF}, 1, 0, 1'b0);
        send_seq('{CH_L, CH_T, CH_T}, 3, 0, 1'b0);
`ifndef UART_LED_CMD_READBACK_EN
        send_seq('{CH_L, CH_Q}, 1, 0, 1'b0);
`else
        set_pio(1'b1);
        avm_readdata = 32'h1;
        send_seq('{CH_L, CH_Q, LF}, 1, 2, 1'b0);
        set_pio(1'b0);
        send_seq('{CH_L, CH_Q, CR}, 2, 0, 1'b0);
`endif

        // busy drop while the response is stalled, then reset during RESP
        send(CH_L, r);
        send(CH_1, r);
        send(LF, r);
        idle(2);
        check_eq("stall_valid", tx_valid, 1);
        rx_valid = 1'b1;
        rx_data  = CH_L;
        model_ovr = 1'b1;
        @(posedge clk);
        #2;
        rx_valid = 1'b0;
        idle(2);
        check_eq("stall_valid2", tx_valid, 1);
        check_eq("stall_data", tx_data, ACK);
        check_eq("stall_ovr", rx_overrun, 1);
        reset_now();

        // reset while the write strobe is on the bus
        send_seq('{CH_L, CH_1, LF}, 1, 0, 1'b0);
        send(CH_L, r);
        send(CH_0, r);
        send(CR, r);
        check_eq("cs_in_write", avm_chipselect, 1);
        reset_now();
        send_seq('{CH_L, CH_T, LF}, 1, 0, 1'b0);

        // random traffic
        for (int k = 0; k < 200; k++) begin
            set_pio(1'($urandom_range(0, 1)));
            q.delete();
            if ($urandom_range(0, 2) != 0) begin
                q.push_back(CH_L);
                n = $urandom_range(0, RB ? 3 : 2);
                q.push_back((n == 0) ? CH_0 : (n == 1) ? CH_1 : (n == 2) ? CH_T : CH_Q);
                q.push_back($urandom_range(0, 1) ? CR : LF);
            end else begin
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        rv = $urandom();
                        q.push_back(rv[7:0]);
                    end else begin
                        q.push_back(soup_set[$urandom_range(0, 7)]);
                    end
                end
            end
            n = $urandom_range(0, 3);
            send_seq(q, 0, n, (n > 0) && ($urandom_range(0, 3) == 0));
        end

        idle(T + 4);
        check_eq("wr_left", exp_wr_q.size(), 0);
        check_eq("tx_left", exp_q.size(), 0);
        check_eq("rd_left", exp_rd, 0);
        check_eq("final_led", led_shadow, model_led);
        check_eq("final_ovr", rx_overrun, model_ovr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
